cmd_decoder: RTL and testbench
==============================

Name: cmd_decoder

Overview:
- Decodes the SUMP command byte stream from the UART receiver into registered configuration strobes.
- Produces the interface the trigger consumes: cmd word, set_mask/set_val/set_cfg strobes with stage select, and arm. Also produces the remaining control strobes for the sampler and controller.
- Sits between the UART receiver and the trigger/sampler/controller blocks, all in one clock domain.

Parameters:
- TIMEOUT_CYCLES, 0, idle cycles between bytes of a long command before the partial command is discarded; 0 disables the timeout.
- CNT_W, 24, width of the inter-byte timeout counter; TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk_i  input  1  system clock, all logic on posedge.
- rst_i  input  1  synchronous reset, active-high.
- rx_data_i  input  8  received byte, valid when rx_stb_i=1.
- rx_stb_i  input  1  one-cycle byte-valid strobe from the UART receiver.
- cmd_o  output  32  data word of the last completed long command, little-endian assembled.
- set_mask_o  output  1  one-cycle pulse for trigger mask write.
- set_val_o  output  1  one-cycle pulse for trigger value write.
- set_cfg_o  output  1  one-cycle pulse for trigger config write.
- stg_o  output  2  trigger stage for the set_* pulses.
- arm_o  output  1  one-cycle pulse on opcode 0x01.
- sft_rst_o  output  1  one-cycle pulse on opcode 0x00.
- id_o  output  1  one-cycle pulse on opcode 0x02, requests the ID reply.
- set_div_o  output  1  one-cycle pulse on long opcode 0x80.
- set_cnt_o  output  1  one-cycle pulse on long opcode 0x81.
- set_flgs_o  output  1  one-cycle pulse on long opcode 0x82.

Behaviour:
- Reset: rst_i=1 at a posedge puts the FSM in IDLE and clears byte index, timeout counter, cmd_o, stg_o and all pulses to 0. Reset mid-command discards the partial command and emits no pulse.
- FSM states are IDLE and DATA. Each accepted byte in DATA increments a 2-bit byte index.
- IDLE, rx_stb_i=1, rx_data_i[7]=0 (short command): decode the opcode. Stay in IDLE.
  - 0x00 gives sft_rst_o.
  - 0x01 gives arm_o.
  - 0x02 gives id_o.
  - 0x11, 0x13 and all other short opcodes are ignored.
- IDLE, rx_stb_i=1, rx_data_i[7]=1 (long command): latch the opcode, set byte index=0, clear the timeout counter, go to DATA.
- DATA, rx_stb_i=1: write the byte into the shadow word at bits [8*idx+7 : 8*idx]. The first data byte is LSB. Clear the timeout counter.
  - When idx=3, copy the shadow word into cmd_o, decode the latched opcode and return to IDLE.
- Long opcode decode:
  - 0xC0..0xCF: stg_o=opcode[3:2]. opcode[1:0]=0 gives set_mask_o, 1 gives set_val_o, 2 gives set_cfg_o, 3 gives no pulse.
  - 0x80, 0x81 and 0x82 give set_div_o, set_cnt_o and set_flgs_o respectively.
  - Any other long opcode consumes its 4 data bytes, updates cmd_o, and emits no pulse.
- Latency: every pulse is high exactly the one cycle after the posedge that accepted the final byte. For short commands that is the opcode byte. For long commands it is data byte 3.
- Output stability: cmd_o and stg_o update on the same edge the pulse rises, and hold until the next completed long command. At most one pulse is high in any cycle.
- In DATA, 0x00 bytes are data and are not soft resets. Five consecutive 0x00 bytes therefore always resynchronise: the partial command completes and later zeros decode as resets.
- Timeout (TIMEOUT_CYCLES>0): in DATA the counter increments on each cycle with rx_stb_i=0. On reaching TIMEOUT_CYCLES the FSM returns to IDLE with no pulse, and cmd_o is unchanged.
  - If rx_stb_i=1 in the same cycle as expiry, the byte wins: it is accepted and the counter clears.
- Back-to-back strobes on consecutive cycles are fully supported, with no dead cycle after command completion.

Decomposition:
- Shared package (logip_pkg) holds:
  - opcode constants: OP_RESET=8'h00, OP_ARM=8'h01, OP_ID=8'h02, OP_XON=8'h11, OP_XOFF=8'h13, OP_DIV=8'h80, OP_CNT=8'h81, OP_FLGS=8'h82, OP_TRG_BASE=8'hC0;
  - the FSM state enum;
  - a typedef for the 5-byte command struct (opcode, data[31:0]).
- No sub-module. The timeout counter is inline.

Test Plan:
- After reset, send 0x01 -> arm_o high for exactly 1 cycle, one cycle after the strobe; all other outputs stay 0.
- Send C5 78 56 34 12 -> cmd_o=32'h12345678, stg_o=2'd1, set_val_o single pulse after the last byte, no other pulse.
- Send CA EF BE AD DE back-to-back with no idle cycles -> cmd_o=32'hDEADBEEF, stg_o=2, set_cfg_o pulse.
- Send 5x 0x00 after a partial command C0 11 22 -> first two zeros complete the mask command with cmd_o=32'h00002211 and set_mask_o pulsing; remaining three zeros give three sft_rst_o pulses.
- TIMEOUT_CYCLES=10: send 81 AA, wait 10 idle cycles, send 02 -> no set_cnt_o, cmd_o unchanged, id_o pulse. Repeat with the byte arriving on the expiry cycle -> byte is accepted.
- Assert rst_i between data bytes 2 and 3 of C0 01 02 03 04 -> no pulse and cmd_o=0. The trailing 04 decodes as an ignored short opcode.

Source files
------------

// File: rtl/logip_pkg.sv
// Shared types and constants for the SUMP command decoder.
// Opcode constants, FSM state enum, command/pulse structs and decode helpers.
// No ports; imported by cmd_decoder_if and cmd_decoder.
package logip_pkg;

  localparam logic [7:0] OP_RESET    = 8'h00;
  localparam logic [7:0] OP_ARM      = 8'h01;
  localparam logic [7:0] OP_ID       = 8'h02;
  localparam logic [7:0] OP_XON      = 8'h11;
  localparam logic [7:0] OP_XOFF     = 8'h13;
  localparam logic [7:0] OP_DIV      = 8'h80;
  localparam logic [7:0] OP_CNT      = 8'h81;
  localparam logic [7:0] OP_FLGS     = 8'h82;
  localparam logic [7:0] OP_TRG_BASE = 8'hC0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  // Long command as received: opcode followed by a 32-bit little-endian word.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] data;
  } cmd_t;

  // One bit per output strobe; at most one bit is ever set.
  typedef struct packed {
    logic sft_rst;
    logic arm;
    logic id;
    logic set_mask;
    logic set_val;
    logic set_cfg;
    logic set_div;
    logic set_cnt;
    logic set_flgs;
  } pulse_t;

  // Short opcodes (bit 7 clear). XON/XOFF and anything unknown decode to nothing.
  function automatic pulse_t decode_short(input logic [7:0] op);
    pulse_t p;
    p = '0;
    case (op)
      OP_RESET: p.sft_rst = 1'b1;
      OP_ARM:   p.arm     = 1'b1;
      OP_ID:    p.id      = 1'b1;
      default:  p         = '0;
    endcase
    return p;
  endfunction

  // Long opcodes (bit 7 set), decoded once the fourth data byte lands.
  function automatic pulse_t decode_long(input logic [7:0] op);
    pulse_t p;
    p = '0;
    if (op[7:4] == OP_TRG_BASE[7:4]) begin
      case (op[1:0])
        2'd0:    p.set_mask = 1'b1;
        2'd1:    p.set_val  = 1'b1;
        2'd2:    p.set_cfg  = 1'b1;
        default: p          = '0;
      endcase
    end else begin
      case (op)
        OP_DIV:  p.set_div  = 1'b1;
        OP_CNT:  p.set_cnt  = 1'b1;
        OP_FLGS: p.set_flgs = 1'b1;
        default: p          = '0;
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/cmd_decoder_if.sv
// Byte-in / strobe-out bundle between UART receiver, decoder and its consumers.
// master: decoder side (takes rx byte+strobe, drives cmd word, stage and pulses).
// slave: environment side (drives rx byte+strobe, observes decoder outputs).
interface cmd_decoder_if;
  import logip_pkg::*;

  logic [7:0]  rx_data_i;
  logic        rx_stb_i;
  logic [31:0] cmd_o;
  logic        set_mask_o;
  logic        set_val_o;
  logic        set_cfg_o;
  logic [1:0]  stg_o;
  logic        arm_o;
  logic        sft_rst_o;
  logic        id_o;
  logic        set_div_o;
  logic        set_cnt_o;
  logic        set_flgs_o;

  modport master (
    input  rx_data_i, rx_stb_i,
    output cmd_o, set_mask_o, set_val_o, set_cfg_o, stg_o, arm_o,
           sft_rst_o, id_o, set_div_o, set_cnt_o, set_flgs_o
  );

  modport slave (
    output rx_data_i, rx_stb_i,
    input  cmd_o, set_mask_o, set_val_o, set_cfg_o, stg_o, arm_o,
           sft_rst_o, id_o, set_div_o, set_cnt_o, set_flgs_o
  );

endinterface

// File: rtl/cmd_decoder.sv
// Purpose: decode SUMP command bytes into registered config strobes, cmd word and stage.
// Latency: every pulse is high the cycle after the edge accepting the final byte.
// Backpressure: none; a byte is accepted on every rx strobe, back-to-back included.
// Ports: clk_i, rst_i (sync, active-high), bus (cmd_decoder_if.master).
module cmd_decoder
  import logip_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 24
) (
  input  logic          clk_i,
  input  logic          rst_i,
  cmd_decoder_if.master bus
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  // Value of the idle counter on the cycle that expires the partial command.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t             cur_q, cur_d;
  logic [31:0]      cmd_q, cmd_d;
  logic [1:0]       stg_q, stg_d;
  pulse_t           pulse_q, pulse_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    cmd_d   = cmd_q;
    stg_d   = stg_q;
    pulse_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_stb_i) begin
          if (bus.rx_data_i[7]) begin
            cur_d.opcode = bus.rx_data_i;
            idx_d        = 2'd0;
            cnt_d        = '0;
            state_d      = ST_DATA;
          end else begin
            pulse_d = decode_short(bus.rx_data_i);
          end
        end
      end

      ST_DATA: begin
        // A byte on the expiry cycle takes priority over the timeout.
        if (bus.rx_stb_i) begin
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
          cur_d.data[{idx_q, 3'b000} +: 8] = bus.rx_data_i;
          if (idx_q == 2'd3) begin
            cmd_d   = {bus.rx_data_i, cur_q.data[23:0]};
            pulse_d = decode_long(cur_q.opcode);
            if (cur_q.opcode[7:4] == OP_TRG_BASE[7:4]) begin
              stg_d = cur_q.opcode[3:2];
            end
            state_d = ST_IDLE;
          end
        end else if (TO_EN) begin
          if (cnt_q == TO_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      cur_q   <= '0;
      cmd_q   <= '0;
      stg_q   <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      cmd_q   <= cmd_d;
      stg_q   <= stg_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.cmd_o      = cmd_q;
  assign bus.stg_o      = stg_q;
  assign bus.sft_rst_o  = pulse_q.sft_rst;
  assign bus.arm_o      = pulse_q.arm;
  assign bus.id_o       = pulse_q.id;
  assign bus.set_mask_o = pulse_q.set_mask;
  assign bus.set_val_o  = pulse_q.set_val;
  assign bus.set_cfg_o  = pulse_q.set_cfg;
  assign bus.set_div_o  = pulse_q.set_div;
  assign bus.set_cnt_o  = pulse_q.set_cnt;
  assign bus.set_flgs_o = pulse_q.set_flgs;

endmodule

// File: tb/tb_cmd_decoder.sv
// Scoreboard bench for cmd_decoder: the driver pushes expected pulse events,
// a negedge monitor pops and compares whenever any pulse is high.
module tb_cmd_decoder;

  // Pulse vector order: sft_rst, arm, id, mask, val, cfg, div, cnt, flgs.
  localparam logic [8:0] P_RST  = 9'b100000000;
  localparam logic [8:0] P_ARM  = 9'b010000000;
  localparam logic [8:0] P_ID   = 9'b001000000;
  localparam logic [8:0] P_MASK = 9'b000100000;
  localparam logic [8:0] P_VAL  = 9'b000010000;
  localparam logic [8:0] P_CFG  = 9'b000001000;
  localparam logic [8:0] P_CNT  = 9'b000000010;

  typedef struct {
    logic [8:0]  pv;
    logic [31:0] cmd;
    logic [1:0]  stg;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   ev = 0;
  exp_t sb[$];

  cmd_decoder_if bus();

  cmd_decoder #(.TIMEOUT_CYCLES(10), .CNT_W(24)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] pulses();
    return {bus.sft_rst_o, bus.arm_o, bus.id_o, bus.set_mask_o, bus.set_val_o,
            bus.set_cfg_o, bus.set_div_o, bus.set_cnt_o, bus.set_flgs_o};
  endfunction

  // Monitor: any high pulse must match the oldest expected event exactly.
  always @(negedge clk) begin
    logic [8:0] pv;
    exp_t e;
    pv = pulses();
    if (!rst && pv != 9'd0) begin
      tests++;
      ev++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse ev%0d got pulses=%b cmd=%h stg=%0d cyc=%0d, required none",
                 ev, pv, bus.cmd_o, bus.stg_o, cyc);
      end else begin
        e = sb.pop_front();
        if (pv !== e.pv || bus.cmd_o !== e.cmd || bus.stg_o !== e.stg || cyc != e.cyc) begin
          fails++;
          $display("FAIL event%0d got pulses=%b cmd=%h stg=%0d cyc=%0d, required pulses=%b cmd=%h stg=%0d cyc=%0d",
                   ev, pv, bus.cmd_o, bus.stg_o, cyc, e.pv, e.cmd, e.stg, e.cyc);
        end
      end
    end
  end

  // Expected pulse appears in the cycle right after the accepting edge.
  task automatic expect_ev(input logic [8:0] pv, input logic [31:0] c, input logic [1:0] s);
    exp_t e;
    e.pv = pv; e.cmd = c; e.stg = s; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Presents one byte for exactly one accepting edge; consecutive calls are back-to-back.
  task automatic send(input logic [7:0] b);
    bus.rx_data_i = b;
    bus.rx_stb_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_stb_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  logic [7:0] trg_c5[5];
  logic [7:0] trg_ca[5];

  initial begin
    trg_c5 = '{8'hC5, 8'h78, 8'h56, 8'h34, 8'h12};
    trg_ca = '{8'hCA, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    bus.rx_data_i = 8'h00;
    bus.rx_stb_i  = 1'b0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_pulses", {23'd0, pulses()}, 32'd0);
    chk("reset_cmd", bus.cmd_o, 32'd0);
    chk("reset_stg", {30'd0, bus.stg_o}, 32'd0);
    idle(1);

    // Short arm
    send(8'h01); expect_ev(P_ARM, 32'h0, 2'd0);
    idle(3);

    // Trigger value write, stage 1, one idle cycle between bytes
    for (int i = 0; i < 5; i++) begin
      send(trg_c5[i]);
      if (i == 4) expect_ev(P_VAL, 32'h12345678, 2'd1);
      else idle(1);
    end
    idle(2);

    // Trigger config, stage 2, back-to-back, then immediately a partial mask + 5 zeros
    for (int i = 0; i < 5; i++) begin
      send(trg_ca[i]);
      if (i == 4) expect_ev(P_CFG, 32'hDEADBEEF, 2'd2);
    end
    send(8'hC0); send(8'h11); send(8'h22);
    send(8'h00);
    send(8'h00); expect_ev(P_MASK, 32'h00002211, 2'd0);
    for (int i = 0; i < 3; i++) begin
      send(8'h00); expect_ev(P_RST, 32'h00002211, 2'd0);
    end
    idle(3);

    // Timeout: 10 idle cycles discard the partial set_cnt
    send(8'h81); send(8'hAA);
    idle(10);
    send(8'h02); expect_ev(P_ID, 32'h00002211, 2'd0);
    idle(2);
    chk("timeout_cmd_held", bus.cmd_o, 32'h00002211);

    // Byte on the expiry cycle wins and the command completes
    send(8'h81); send(8'hAA);
    idle(9);
    send(8'hBB); send(8'hCC);
    send(8'hDD); expect_ev(P_CNT, 32'hDDCCBBAA, 2'd0);
    idle(3);
    chk("expiry_byte_cmd", bus.cmd_o, 32'hDDCCBBAA);

    // Reset between data bytes 2 and 3
    send(8'hC0); send(8'h01); send(8'h02); send(8'h03);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midreset_cmd", bus.cmd_o, 32'd0);
    chk("midreset_stg", {30'd0, bus.stg_o}, 32'd0);
    send(8'h04);
    idle(3);
    chk("after_04_cmd", bus.cmd_o, 32'd0);
    send(8'h01); expect_ev(P_ARM, 32'h0, 2'd0);
    idle(5);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
